// File: rtl/cpu_sequencer_if.sv
// Program-memory fetch handshake and datapath control bundle for the CPU sequencer.
// The master side belongs to the sequencer; the slave side to memory and datapath.
interface cpu_sequencer_if #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8
);
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ready;
   logic [DATA_W-1:0] mem_rdata;
   logic              alu_zero;
   logic [2:0]        alu_op;
   logic [3:0]        imm;
   logic              reg_we;
   logic              out_we;

   modport master (
      output mem_req, mem_addr, alu_op, imm, reg_we, out_we,
      input  mem_ready, mem_rdata, alu_zero
   );

   modport slave (
      input  mem_req, mem_addr, alu_op, imm, reg_we, out_we,
      output mem_ready, mem_rdata, alu_zero
   );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute controller: owns PC and IR, fetches over a
// req/ready handshake and pulses the datapath strobes once per executed instruction.
module cpu_sequencer #(
   parameter int unsigned       ADDR_W   = 8,
   parameter int unsigned       DATA_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               reset,
   cpu_sequencer_if.master    bus,
   output logic [ADDR_W-1:0]  pc,
   output logic [DATA_W-1:0]  instruction,
   output logic               halted
);

   typedef enum logic [2:0] {StBoot, StFetch, StDecode, StExecute, StHalt} state_e;

   localparam logic [3:0] OpLdi = 4'h1;
   localparam logic [3:0] OpOr  = 4'h5;
   localparam logic [3:0] OpJmp = 4'h6;
   localparam logic [3:0] OpJz  = 4'h7;
   localparam logic [3:0] OpOut = 4'h8;
   localparam logic [3:0] OpHlt = 4'hF;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic [3:0]        opcode;
   logic [2:0]        dec_alu_op;
   logic [ADDR_W-1:0] jump_target;

   assign opcode      = ir_q[7:4];
   assign jump_target = {{(ADDR_W-4){1'b0}}, ir_q[3:0]};

   // LDI..OR map onto alu_op 0..4 in opcode order; everything else leaves PASS_IMM.
   always_comb begin
      dec_alu_op = 3'd0;
      if (opcode >= OpLdi && opcode <= OpOr) begin
         dec_alu_op = 3'(opcode - OpLdi);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StBoot;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      ir_d        = ir_q;
      bus.mem_req = 1'b0;
      bus.alu_op  = 3'd0;
      bus.imm     = 4'd0;
      bus.reg_we  = 1'b0;
      bus.out_we  = 1'b0;
      case (state_q)
         StBoot: state_d = StFetch;
         StFetch: begin
            bus.mem_req = 1'b1;
            if (bus.mem_ready) begin
               ir_d    = bus.mem_rdata;
               pc_d    = pc_q + ADDR_W'(1);
               state_d = StDecode;
            end
         end
         StDecode: begin
            bus.alu_op = dec_alu_op;
            bus.imm    = ir_q[3:0];
            state_d    = StExecute;
         end
         StExecute: begin
            bus.alu_op = dec_alu_op;
            bus.imm    = ir_q[3:0];
            state_d    = StFetch;
            if (opcode >= OpLdi && opcode <= OpOr) bus.reg_we = 1'b1;
            if (opcode == OpOut) bus.out_we = 1'b1;
            // PC was already incremented in FETCH; a taken jump simply overrides it.
            if (opcode == OpJmp || (opcode == OpJz && bus.alu_zero)) pc_d = jump_target;
            if (opcode == OpHlt) state_d = StHalt;
         end
         StHalt: state_d = StHalt;
         default: state_d = StBoot;
      endcase
   end

   // Address tracks the PC continuously, so it is stable for the whole handshake.
   assign bus.mem_addr = pc_q;
   assign pc           = pc_q;
   assign instruction  = ir_q;
   assign halted       = (state_q == StHalt);

endmodule
